// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//
// Registered ALU for a multi-cycle CPU datapath. Single-cycle logic/arith ops
// complete one cycle after the accept edge; unsigned multiply (shift-add,
// LSB-first) and unsigned divide (restoring, MSB-first) iterate once per
// cycle for WIDTH cycles. A start/busy/done handshake lets the control FSM
// stall until the result is ready.
//
// Optional feature macro: MCALU_DIV_EN
//   defined   : DIVU (4'b1001) is implemented.
//   undefined : no divider logic; 4'b1001 is reported as an illegal opcode.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   start      in   operation request, accepted only when idle
//   alu_ctrl   in   4-bit opcode, sampled at accept
//   a, b       in   WIDTH-bit operands, sampled at accept
//   result     out  primary result (low product / quotient)
//   result_hi  out  high product / remainder, 0 for other ops
//   zero       out  registered result==0
//   busy       out  high while an operation is in flight (BUSY and DONE)
//   done       out  one-cycle completion pulse
//   err        out  illegal opcode or divide-by-zero, valid with done
// -----------------------------------------------------------------------------
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_SET  = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // b_q is the multiplicand for MULU and the divisor for DIVU.
    logic [WIDTH-1:0] b_q, b_d;
    // Iteration registers: {hi,lo} is the partial product for MULU, and
    // {remainder, dividend/quotient shift register} for DIVU.
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
`ifdef MCALU_DIV_EN
    logic             is_div_q, is_div_d;
`endif

    // ---------------------------------------------------------------
    // Single-cycle result, computed straight from the input operands so
    // it can be registered on the accept edge.
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] quick_res;
    logic             quick_err;

    always_comb begin
        quick_res = '0;
        quick_err = 1'b0;
        case (alu_ctrl)
            OP_ADD:  quick_res = a + b;
            OP_SUB:  quick_res = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
            OP_AND:  quick_res = a & b;
            OP_OR:   quick_res = a | b;
            OP_XOR:  quick_res = a ^ b;
            // a-b is zero exactly when a==b, so zero falls out of result.
            OP_BEQ:  quick_res = a - b;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SET:  quick_res = b;
`ifndef MCALU_DIV_EN
            OP_DIVU: quick_err = 1'b1;
`endif
            default: quick_err = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------
    // One iteration step of the multiplier (and divider when enabled).
    // ---------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

`ifdef MCALU_DIV_EN
    logic [WIDTH:0] div_shift, div_diff;
    logic           div_ge;

    // Remainder is always < divisor, so the shifted value fits WIDTH+1 bits
    // and bit WIDTH of the difference is its sign.
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_diff[WIDTH];

    always_comb begin
        if (is_div_q) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {work_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
    end
`else
    assign step_hi = mul_sum[WIDTH:1];
    assign step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
`endif

    // ---------------------------------------------------------------
    // Next-state logic. Visible outputs are only written on the edge
    // that enters DONE, so they hold steady throughout BUSY.
    // ---------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_d         = b_q;
        work_hi_d   = work_hi_q;
        work_lo_d   = work_lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        err_d       = err_q;
`ifdef MCALU_DIV_EN
        is_div_d    = is_div_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d = b;
                    if (alu_ctrl == OP_MULU) begin
                        cnt_d     = CNT_W'(WIDTH);
                        work_hi_d = '0;
                        work_lo_d = a;
                        state_d   = S_BUSY;
`ifdef MCALU_DIV_EN
                        is_div_d  = 1'b0;
                    end else if ((alu_ctrl == OP_DIVU) && (b != '0)) begin
                        cnt_d     = CNT_W'(WIDTH);
                        work_hi_d = '0;
                        work_lo_d = a;
                        is_div_d  = 1'b1;
                        state_d   = S_BUSY;
                    end else if (alu_ctrl == OP_DIVU) begin
                        // Divide by zero: no iterations, all-ones quotient.
                        result_d    = '1;
                        result_hi_d = a;
                        zero_d      = 1'b0;
                        err_d       = 1'b1;
                        state_d     = S_DONE;
`endif
                    end else begin
                        result_d    = quick_res;
                        result_hi_d = '0;
                        zero_d      = (quick_res == '0);
                        err_d       = quick_err;
                        state_d     = S_DONE;
                    end
                end
            end

            S_BUSY: begin
                cnt_d     = cnt_q - CNT_W'(1);
                work_hi_d = step_hi;
                work_lo_d = step_lo;
                if (cnt_q == CNT_W'(1)) begin
                    result_d    = step_lo;
                    result_hi_d = step_hi;
                    zero_d      = (step_lo == '0);
                    err_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            b_q         <= '0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            err_q       <= 1'b0;
`ifdef MCALU_DIV_EN
            is_div_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b_q         <= b_d;
            work_hi_q   <= work_hi_d;
            work_lo_q   <= work_lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
`ifdef MCALU_DIV_EN
            is_div_q    <= is_div_d;
`endif
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
//
// Scoreboard bench for multicycle_alu (WIDTH=32). The driver pushes the
// expected response of every accepted request into a queue; a monitor pops
// and compares on each done pulse, and also checks that the visible outputs
// hold between completions. Expected values come from a plain-arithmetic
// reference model. Honours MCALU_DIV_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_multicycle_alu;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] a, b;
    logic [W-1:0] result, result_hi;
    logic         zero, busy, done, err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    logic [W-1:0] held_res, held_hi;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alu_ctrl  (alu_ctrl),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: operation semantics as plain arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [2*W-1:0] p;
        e.res = '0; e.hi = '0; e.err = 1'b0; e.lat = 1; e.acc = 0;
        case (op)
            4'd0:  e.res = x + y;
            4'd1:  e.res = x - y;
            4'd2:  e.res = x & y;
            4'd3:  e.res = x | y;
            4'd4:  e.res = x ^ y;
            4'd5:  e.res = x - y;
            4'd6:  e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            4'd7:  e.res = (x < y) ? W'(1) : W'(0);
            4'd8: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.res = p[W-1:0];
                e.hi  = p[2*W-1:W];
                e.lat = W + 1;
            end
`ifdef MCALU_DIV_EN
            4'd9: begin
                if (y == 0) begin
                    e.res = '1; e.hi = x; e.err = 1'b1;
                end else begin
                    e.res = x / y; e.hi = x % y; e.lat = W + 1;
                end
            end
`endif
            4'd14: e.res = y;
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Monitor: compares on done, otherwise checks outputs are held.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_res = '0;
            held_hi  = '0;
        end else if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",    result,    e.res);
                chk("result_hi", result_hi, e.hi);
                chk("zero",      zero,      e.zero);
                chk("err",       err,       e.err);
                chk("latency",   cyc - e.acc + 1, e.lat);
            end
            held_res = result;
            held_hi  = result_hi;
        end else begin
            chk("hold_result",    result,    held_res);
            chk("hold_result_hi", result_hi, held_hi);
        end
    end

    // Issue one request when idle; junk start pulses while busy.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   t;
        t = 0;
        while (busy && t < 300) begin @(negedge clk); t++; end
        chk("idle_timeout", busy, 1'b0);
        if (busy) return;
        start = 1'b1; alu_ctrl = op; a = av; b = bv;
        e = model(op, av, bv);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        t = 0;
        while (busy && t < 300) begin
            start = 1'($urandom % 2); alu_ctrl = 4'($urandom); a = $urandom; b = $urandom;
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        chk("done_timeout", busy, 1'b0);
    endtask

    logic [3:0]   d_op[10] = '{4'd0, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd5, 4'd5, 4'd10, 4'd14};
    logic [W-1:0] d_a[10]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd100, 32'd5, 32'h1234, 32'h1234, 32'h55, 32'h0};
    logic [W-1:0] d_b[10]  = '{32'd1, 32'd1, 32'd1, 32'hFFFFFFFF,
                               32'd7, 32'd0, 32'h1234, 32'h1235, 32'h66, 32'hA5A5};

    initial begin
        int dc;
        rst_n = 1'b0; start = 1'b0; alu_ctrl = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_err", err, 1'b0);

        for (int i = 0; i < 10; i++) issue(d_op[i], d_a[i], d_b[i]);

        // Random mix with biased operands.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            case ($urandom % 4)
                0: rb = ($urandom % 2) ? '0 : ra;
                1: rb = W'($urandom % 64);
                default: rb = $urandom;
            endcase
            issue(4'($urandom), ra, rb);
        end

        // Back-to-back ADD with start held high: one accept every 2 cycles.
        dc = done_cnt;
        start = 1'b1; alu_ctrl = 4'd0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) begin
                exp_t e;
                a = $urandom; b = $urandom;
                e = model(4'd0, a, b);
                e.acc = cyc + 1;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_done_count", done_cnt - dc, 10);

        // Reset in the middle of a MULU: aborted, no late done.
        start = 1'b1; alu_ctrl = 4'd8; a = 32'h12345; b = 32'h777;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, '0);
        chk("abort_result_hi", result_hi, '0);
        chk("abort_zero", zero, 1'b1);
        dc = done_cnt;
        repeat (W + 5) @(negedge clk);
        chk("no_late_done", done_cnt - dc, 0);

        issue(4'd1, 32'd3, 32'd5);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered ALU for the multi-cycle CPU datapath.
- Adds iterative unsigned multiply and divide alongside the single-cycle logic/arith ops.
- Uses a start/busy/done handshake, so the control FSM stalls in its EX state until `done`.
- Produces a registered `zero` flag for branches and an `err` flag for illegal opcodes and divide-by-zero.

Parameters:
- WIDTH, 32, datapath width in bits; legal range ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request; accepted only in IDLE.
- alu_ctrl  input  4  operation select, sampled at accept.
- a  input  WIDTH  operand A, sampled at accept.
- b  input  WIDTH  operand B, sampled at accept.
- result  output  WIDTH  primary result (low product / quotient).
- result_hi  output  WIDTH  high product / remainder; 0 for other ops.
- zero  output  1  registered: result==0.
- busy  output  1  high in BUSY and DONE.
- done  output  1  single-cycle completion pulse.
- err  output  1  high with done for illegal op or divide-by-zero.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; result, result_hi, counter and operand regs cleared; zero=1; busy=0; done=0; err=0.
- Reset mid-operation aborts the operation; no done is issued.
- Opcodes:
  - 0000 ADD.
  - 0001 SUB (a+~b+1).
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 BEQ: result=a-b, zero=(a==b).
  - 0110 SLT, signed: result={0..,1} if a<b.
  - 0111 SLTU.
  - 1000 MULU.
  - 1001 DIVU.
  - 1110 SET: result=b.
  - All others: illegal; result=0, result_hi=0, err=1.
- Arithmetic is modulo 2^WIDTH; carry out is discarded. MULU gives the full 2·WIDTH product as {result_hi,result}.
- FSM states and transitions:
  - IDLE: start=1 latches alu_ctrl/a/b.
    - MULU, or DIVU with b≠0 → BUSY with counter=WIDTH.
    - All other ops compute in the same edge → DONE.
  - BUSY: one iteration per cycle; counter decrements; counter reaching 0 → DONE.
    - MULU: shift-add, LSB-first on the multiplier.
    - DIVU: restoring division, MSB-first.
  - DONE: done=1 for exactly one cycle; result, result_hi, zero and err become valid and held → IDLE.
- Outputs hold their values until the next accepted operation's DONE. They must not change while BUSY.
- Latency, counted from the accept edge to the cycle with done=1:
  - Single-cycle ops: 1 cycle.
  - MULU/DIVU: WIDTH+1 cycles.
- Back-to-back: start asserted in the DONE cycle is ignored. Start is accepted again the following cycle (IDLE).
- start while busy=1 is ignored. Operand changes during BUSY have no effect.
- DIVU with b=0: no iteration. Goes to DONE after 1 cycle with result=all-ones, result_hi=a, err=1.
- zero is computed from the final result only, never from intermediate iteration values. For BEQ it equals (a==b).

Optional Feature:
- Macro: MCALU_DIV_EN.
- Defined: DIVU (1001) is implemented as above.
- Undefined:
  - No divider logic is synthesised.
  - 1001 is treated as illegal: 1-cycle latency, result=0, result_hi=0, err=1, zero=1.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles during a MULU in BUSY → next cycle state IDLE, busy=0, done=0, result=0, zero=1, no late done pulse.
- WIDTH=32, ADD a=0xFFFFFFFF b=1 → done 1 cycle after accept, result=0, zero=1, err=0. SLT a=0xFFFFFFFF b=1 → result=1. SLTU same operands → result=0.
- WIDTH=32, MULU a=0xFFFFFFFF b=0xFFFFFFFF → done exactly 33 cycles after accept, result_hi=0xFFFFFFFE, result=0x00000001. start pulses during BUSY are ignored.
- WIDTH=32, DIVU a=100 b=7 → result=14, result_hi=2, latency 33. DIVU a=5 b=0 → latency 1, result=0xFFFFFFFF, result_hi=5, err=1. With MCALU_DIV_EN undefined: result=0, err=1.
- BEQ a=0x1234 b=0x1234 → zero=1. BEQ a=0x1234 b=0x1235 → zero=0, result=0xFFFFFFFF. Illegal opcode 1010 → err=1, result=0.
- Back-to-back: start held high continuously with ADD → accepts every 2 cycles. done pulses are one cycle wide and each shows the matching result.
